machine_timer: RTL
==================

Name: machine_timer

Overview:
Memory-mapped machine timer. It owns the 64-bit mtime and mtimecmp registers and the machine software interrupt bit, and sits on the peripheral bus beside the CSR file. The CSR file consumes its outputs: timer_interrupt drives mip.MTIP, software_interrupt drives mip.MSIP, and mtime/mtimecmp are exported so the core and CSR file read them through ports rather than reaching into top.

Parameters:
PRESCALE, 1, clock cycles per mtime increment; legal range 1..65535.
PRESCALE_WIDTH, 16, width of the internal prescale counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
address  input  3  word offset: 0 mtime[31:0], 1 mtime[63:32], 2 mtimecmp[31:0], 3 mtimecmp[63:32], 4 msip (bit 0); 5-7 unmapped.
read_enable  input  1  single-cycle read request.
write_enable  input  1  single-cycle write request; full 32-bit words only.
write_value  input  32  write data.
read_value  output  32  registered read data.
read_valid  output  1  high for exactly one cycle, the cycle after read_enable.
mtime  output  64  current mtime register.
mtimecmp  output  64  current mtimecmp register.
timer_interrupt  output  1  registered (mtime >= mtimecmp).
software_interrupt  output  1  msip bit.

Behaviour:
- Reset (reset_n low, asynchronous) sets: mtime 0, mtimecmp 64'hFFFF_FFFF_FFFF_FFFF, msip 0, prescale counter 0, timer_interrupt 0, read_value 0, read_valid 0.
- Prescaler: the counter counts 0..PRESCALE-1.
  - On the edge where the counter equals PRESCALE-1, mtime increments by 1 and the counter returns to 0.
  - With PRESCALE=1, mtime increments every cycle.
- Wrap-around: mtime 64'hFFFF_FFFF_FFFF_FFFF increments to 0. The carry from the low half into the high half is a full 64-bit add.
- mtime write (address 0 or 1):
  - Replaces only the addressed half; the other half holds its current value.
  - Suppresses that cycle's increment and clears the prescale counter.
  - The written value is visible on the mtime port after the edge.
- mtimecmp write (address 2 or 3): replaces only the addressed half. The other half is unchanged, so software must use the write-high-all-ones-first sequence to avoid spurious interrupts.
- msip write (address 4): msip <= write_value[0]. software_interrupt equals msip.
- Writes to addresses 5-7 are ignored.
- Read latency is 1 cycle.
  - The value is sampled from register state before the edge, then read_value and read_valid update at the edge.
  - read_value holds its last value while read_valid is low.
  - Unmapped addresses return 0. Address 4 returns {31'b0, msip}.
- Simultaneous read and write in the same cycle is legal. The read returns the pre-write value.
- timer_interrupt:
  - Updated every edge as (mtime >= mtimecmp), unsigned 64-bit, using pre-edge register values. This gives one cycle of lag after the compare becomes true or false.
  - It is level-sensitive with no latching. It deasserts one cycle after mtimecmp is raised above mtime or mtime is written below mtimecmp.
- Reset asserted mid-operation aborts any pending read: read_valid is 0 from reset assertion until the first read after release.
- No backpressure: every request completes. read_enable may be asserted every cycle.

Test Plan:
1. Reset release with PRESCALE=1, no bus traffic for 10 cycles -> mtime=10, timer_interrupt=0, software_interrupt=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
2. PRESCALE=4: write mtime low=0 at cycle N, then idle 12 cycles -> mtime=3, incrementing exactly every 4th edge after the write.
3. Write mtimecmp high=0, then low=20, with mtime counting from 0 (PRESCALE=1) -> timer_interrupt rises one cycle after mtime first equals 20. Then write mtimecmp low=1000 -> timer_interrupt falls one cycle after the write.
4. Write mtime high=32'hFFFF_FFFF, low=32'hFFFF_FFFE -> two increments later mtime=0, with a correct carry across the half boundary.
5. Read address 0 while write_enable writes 5 to address 0 in the same cycle -> read_valid next cycle with the old low word; the following read of address 0 returns 5 (PRESCALE large).
6. Write msip=1, read address 4 -> read_value=1, software_interrupt=1. Assert reset_n low mid-read -> read_valid=0, software_interrupt=0, mtime=0 immediately (asynchronous).

Source files
------------

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp, prescaled tick, msip bit,
// and a one-cycle-latency register read port on the peripheral bus.
module machine_timer #(
    parameter int PRESCALE       = 1,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read_enable,
    input  logic        write_enable,
    input  logic [31:0] write_value,
    output logic [31:0] read_value,
    output logic        read_valid,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    localparam logic [PRESCALE_WIDTH-1:0] LP_LAST = PRESCALE_WIDTH'(PRESCALE - 1);

    logic [63:0]               r_mtime;
    logic [63:0]               r_mtimecmp;
    logic                      r_msip;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_timer_interrupt;
    logic [31:0]               r_read_value;
    logic                      r_read_valid;

    logic                      w_tick;
    logic                      w_wr_mtime_lo;
    logic                      w_wr_mtime_hi;
    logic                      w_wr_cmp_lo;
    logic                      w_wr_cmp_hi;
    logic                      w_wr_msip;
    logic [31:0]               w_read_word;

    assign w_tick        = (r_prescale == LP_LAST);
    assign w_wr_mtime_lo = write_enable && (address == 3'd0);
    assign w_wr_mtime_hi = write_enable && (address == 3'd1);
    assign w_wr_cmp_lo   = write_enable && (address == 3'd2);
    assign w_wr_cmp_hi   = write_enable && (address == 3'd3);
    assign w_wr_msip     = write_enable && (address == 3'd4);

    always_comb begin
        w_read_word = 32'd0;
        case (address)
            3'd0:    w_read_word = r_mtime[31:0];
            3'd1:    w_read_word = r_mtime[63:32];
            3'd2:    w_read_word = r_mtimecmp[31:0];
            3'd3:    w_read_word = r_mtimecmp[63:32];
            3'd4:    w_read_word = {31'd0, r_msip};
            default: w_read_word = 32'd0;
        endcase
    end

    // A software write to either mtime half wins over the tick and restarts the prescaler.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mtime    <= 64'd0;
            r_prescale <= '0;
        end else if (w_wr_mtime_lo) begin
            r_mtime    <= {r_mtime[63:32], write_value};
            r_prescale <= '0;
        end else if (w_wr_mtime_hi) begin
            r_mtime    <= {write_value, r_mtime[31:0]};
            r_prescale <= '0;
        end else if (w_tick) begin
            r_mtime    <= r_mtime + 64'd1;
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PRESCALE_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_msip     <= 1'b0;
        end else begin
            if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= write_value;
            if (w_wr_cmp_hi) r_mtimecmp[63:32] <= write_value;
            if (w_wr_msip)   r_msip            <= write_value[0];
        end
    end

    // Compare uses pre-edge values, so the interrupt lags the condition by one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timer_interrupt <= 1'b0;
            r_read_value      <= 32'd0;
            r_read_valid      <= 1'b0;
        end else begin
            r_timer_interrupt <= (r_mtime >= r_mtimecmp);
            r_read_valid      <= read_enable;
            if (read_enable) r_read_value <= w_read_word;
        end
    end

    assign read_value         = r_read_value;
    assign read_valid         = r_read_valid;
    assign mtime              = r_mtime;
    assign mtimecmp           = r_mtimecmp;
    assign timer_interrupt    = r_timer_interrupt;
    assign software_interrupt = r_msip;

endmodule
